// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared time-base constants and counter width helper
// Contents:
//   CLK_HZ_DEF  : board clock frequency in Hz
//   TICK_HZ_DEF : default tick rate in Hz
//   cnt_width() : bits needed to hold a count in 0..n-1, never less than 1
package clock_pkg;

  localparam int CLK_HZ_DEF  = 100_000_000;
  localparam int TICK_HZ_DEF = 1;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo counter with runtime terminal value and registered wrap pulse
// Ports:
//   clk   in  1  clock
//   rst   in  1  synchronous active-high reset, count and wrap to 0
//   clr   in  1  synchronous restart of the count, wrap forced low
//   en    in  1  advance the count; low holds it
//   last  in  W  terminal value; count wraps when it is at or beyond this value
//   count out W  current count
//   wrap  out 1  high for one cycle after the edge on which count returned to 0
module mod_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         wrap
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      // >= rather than == so that lowering 'last' below the current count
      // (fast mode engaged late in a period) wraps at once instead of
      // running on to 2^W.
      if (count >= last) begin
        count <= '0;
        wrap  <= 1'b1;
      end else begin
        count <= count + W'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - clock divider producing a tick pulse, 50% blink and debug phase
// Ports:
//   clk   in  1      system clock
//   rst   in  1      synchronous active-high reset
//   en    in  1      count enable; low pauses the divider
//   clr   in  1      restart the current period (blink comes back high)
//   fast  in  1      1 selects the shortened period PERIOD/FAST_DIV
//   tick  out 1      one-cycle pulse per active period
//   blink out 1      high for the first half of each period
//   phase out CNT_W  current divider count
module tick_gen
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_DEF,
  parameter int TICK_HZ  = TICK_HZ_DEF,
  parameter int FAST_DIV = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   clr,
  input  logic                                   fast,
  output logic                                   tick,
  output logic                                   blink,
  output logic [cnt_width(CLK_HZ/TICK_HZ)-1:0]   phase
);

  localparam int PERIOD  = CLK_HZ / TICK_HZ;
  localparam int FPERIOD = PERIOD / FAST_DIV;
  localparam int CNT_W   = cnt_width(PERIOD);

  localparam logic [CNT_W-1:0] LAST_N = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LAST_F = CNT_W'(FPERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_N = CNT_W'(PERIOD / 2);
  localparam logic [CNT_W-1:0] HALF_F = CNT_W'(FPERIOD / 2);

  if (CLK_HZ % TICK_HZ != 0) begin : g_bad_tick_hz
    $error("tick_gen: CLK_HZ must be a multiple of TICK_HZ");
  end
  if (PERIOD % FAST_DIV != 0) begin : g_bad_fast_div
    $error("tick_gen: PERIOD must be a multiple of FAST_DIV");
  end
  if (FPERIOD < 2) begin : g_bad_fperiod
    $error("tick_gen: PERIOD/FAST_DIV must be at least 2");
  end

  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] phase_next;

  always_comb begin
    last = fast ? LAST_F : LAST_N;
    half = fast ? HALF_F : HALF_N;
    // Value the counter will take on an enabled edge; blink is registered
    // from it so that it changes on the same edge as phase.
    phase_next = (phase >= last) ? '0 : phase + CNT_W'(1);
  end

  mod_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (en),
    .last  (last),
    .count (phase),
    .wrap  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= 1'b0;
    end else if (clr) begin
      blink <= 1'b1;
    end else if (en) begin
      blink <= (phase_next < half);
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - scoreboard bench for tick_gen with directed and random stimulus
module tb_tick_gen;

  localparam int CLK_HZ   = 20;
  localparam int TICK_HZ  = 2;
  localparam int FAST_DIV = 5;
  localparam int P        = CLK_HZ / TICK_HZ;
  localparam int FP       = P / FAST_DIV;
  localparam int CW       = 4;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          clr  = 1'b0;
  logic          en   = 1'b0;
  logic          fast = 1'b0;
  logic          tick;
  logic          blink;
  logic [CW-1:0] phase;

  tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .FAST_DIV (FAST_DIV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .fast  (fast),
    .tick  (tick),
    .blink (blink),
    .phase (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tick;
    int blink;
    int phase;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference state: integer phase and blink level.
  int m_ph    = 0;
  int m_blink = 0;

  task automatic model_push(input bit r, input bit c, input bit e, input bit f);
    exp_t x;
    int   ap;
    int   t;
    ap = f ? FP : P;
    t  = 0;
    if (r) begin
      m_ph = 0; m_blink = 0;
    end else if (c) begin
      m_ph = 0; m_blink = 1;
    end else if (e) begin
      if (m_ph >= ap - 1) begin
        m_ph = 0; t = 1;
      end else begin
        m_ph = m_ph + 1;
      end
      m_blink = (m_ph < ap / 2) ? 1 : 0;
    end
    x.tick = t; x.blink = m_blink; x.phase = m_ph;
    q.push_back(x);
  endtask

  // Monitor: one expectation per driven edge, compared just after that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        tests++;
        if (tick !== x.tick[0] || blink !== x.blink[0] || phase !== CW'(x.phase)) begin
          fails++;
          $display("FAIL scoreboard cyc=%0d tick=%b blink=%b phase=%0d required tick=%0d blink=%0d phase=%0d",
                   cyc, tick, blink, phase, x.tick, x.blink, x.phase);
        end
      end
    end
  end

  task automatic step(input bit r, input bit c, input bit e, input bit f, output bit t);
    @(negedge clk);
    rst = r; clr = c; en = e; fast = f;
    model_push(r, c, e, f);
    @(posedge clk);
    #2;
    t = tick;
  endtask

  task automatic check(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic run_to_phase(input int target, input bit f);
    bit t;
    for (int i = 0; i < 40 && m_ph != target; i++) step(0, 0, 1, f, t);
  endtask

  task automatic steps_to_tick(input bit f, input int max, output int n);
    bit t;
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(0, 0, 1, f, t);
      if (t) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    bit t;
    int n;
    int ticks;
    int misplaced;

    // Reset
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, t);
    check("reset_phase", int'(phase), 0);
    check("reset_blink", int'(blink), 0);

    // Normal run: ticks on enabled cycles 10, 20, 30 only
    ticks = 0; misplaced = 0;
    for (int i = 1; i <= 35; i++) begin
      step(0, 0, 1, 0, t);
      if (t) ticks++;
      if (t != (i % 10 == 0)) misplaced++;
    end
    check("normal_tick_count", ticks, 3);
    check("normal_tick_position_errors", misplaced, 0);
    check("normal_end_phase", int'(phase), 5);

    // Pause at phase 4
    run_to_phase(4, 0);
    ticks = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, t);
      if (t) ticks++;
    end
    check("pause_phase_hold", int'(phase), 4);
    check("pause_no_tick", ticks, 0);
    steps_to_tick(0, 20, n);
    check("pause_resume_gap", n, 6);

    // Fast switch at phase 7: wraps on that edge with a tick
    run_to_phase(7, 0);
    step(0, 0, 1, 1, t);
    check("fast_switch_tick", int'(t), 1);
    check("fast_switch_phase", int'(phase), 0);
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 1, t);
      if (t) ticks++;
    end
    check("fast_tick_count", ticks, 3);

    // Back to normal: no tick on the switch edge
    step(0, 0, 1, 0, t);
    check("slow_switch_no_tick", int'(t), 0);

    // Clear beats enable at phase 9
    run_to_phase(9, 0);
    step(0, 1, 1, 0, t);
    check("clr_tick", int'(t), 0);
    check("clr_phase", int'(phase), 0);
    check("clr_blink", int'(blink), 1);
    steps_to_tick(0, 20, n);
    check("clr_next_tick_gap", n, 10);

    // Reset mid-period at phase 6
    run_to_phase(6, 0);
    step(1, 0, 1, 0, t);
    check("rst_mid_tick", int'(t), 0);
    check("rst_mid_phase", int'(phase), 0);
    check("rst_mid_blink", int'(blink), 0);
    steps_to_tick(0, 20, n);
    check("rst_next_tick_gap", n, 10);

    // Randomised traffic against the reference model
    begin
      bit f;
      f = 0;
      for (int i = 0; i < 3000; i++) begin
        bit r, c, e;
        r = ($urandom_range(0, 99) < 2);
        c = ($urandom_range(0, 99) < 4);
        e = ($urandom_range(0, 99) < 75);
        if ($urandom_range(0, 99) < 6) f = ~f;
        step(r, c, e, f, t);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised time-base generator for the alarm-clock datapath. It divides the system clock into a single-cycle `tick` at `TICK_HZ`. It also provides a 50 % duty `blink` square wave for display flashing, plus a `fast` mode that shortens the period by `FAST_DIV` while the user sets the time. It sits between the board clock and the seconds/minutes/hours counters and replaces fixed-constant per-second dividers.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency in Hz
- `TICK_HZ`, 1, normal tick rate in Hz; `CLK_HZ % TICK_HZ == 0` required
- `FAST_DIV`, 64, fast-mode speed-up factor; `PERIOD % FAST_DIV == 0` and `PERIOD/FAST_DIV >= 2` required
- Derived: `PERIOD = CLK_HZ/TICK_HZ`, `FPERIOD = PERIOD/FAST_DIV`, `CNT_W = $clog2(PERIOD)`
- `clk`  in  1  system clock; one clock domain, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  count enable; low pauses the divider
- `clr`  in  1  synchronous phase clear; restarts the current period
- `fast`  in  1  1 = period is `FPERIOD`, 0 = period is `PERIOD`
- `tick`  out  1  one-cycle pulse, once per active period
- `blink`  out  1  high for first half of each period, low for second half
- `phase`  out  CNT_W  current divider count, for debug/bench

## Operation
- Active period `AP` = `fast ? FPERIOD : PERIOD`; terminal value `LAST = AP-1`; half point `H = AP/2`.
- Priority on each edge: `rst` > `clr` > `en`.
- `rst`: `phase`=0, `tick`=0, `blink`=0.
- `clr` (no rst): `phase`=0, `tick`=0, `blink`=1.
- `en`=1, no rst/clr: if `phase >= LAST` then `phase`←0 and `tick`←1, else `phase`←`phase`+1 and `tick`←0.
- `blink`←(`phase_next` < `H`).
- `en`=0: `phase` and `blink` hold, `tick`←0. No wrap occurs while disabled, including at `phase == LAST`.
- `>=` comparison is mandatory. Switching `fast` 0→1 when `phase > FPERIOD-1` wraps on the next enabled cycle with one tick, never runs to 2^CNT_W.
- Switching `fast` 1→0 continues counting toward `PERIOD-1`; no tick is emitted on the switch edge itself.
- `fast` is sampled every cycle; no synchronisation inside the block. Callers supply a synchronised level.

## Timing
- Period is exactly `AP` enabled cycles between successive `tick` pulses; no off-by-one.
- `tick` is registered: high for the one cycle after the edge on which `phase` wrapped to 0. It is never high for two consecutive cycles.
- With `en` held high from reset release, the first `tick` appears `AP` cycles after the first enabled edge.
- `blink` is registered alongside `phase`. It is high for `H` enabled cycles and low for `AP-H` enabled cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- `clr` and `en` both high: `clr` wins, `tick` stays 0 that cycle.
- `rst` mid-period discards phase; no tick is emitted for the partial period.

## Structure
- Shared `clock_pkg`: `CLK_HZ` default, `TICK_HZ` default, and a `clog2`-based width helper. The seconds/minutes counters use the same constants.
- Single natural sub-module `mod_counter` (parameter `W`; inputs `rst`, `clr`, `en`, `last`; outputs `count`, `wrap`). `tick_gen` instantiates one `mod_counter` and muxes `last` from `fast`. The `blink` compare stays in `tick_gen`.
- Elaboration-time assertions check the divisibility and `FPERIOD >= 2` rules.
- Target size: about 150 lines of RTL including `mod_counter`.

## Test plan
Bench parameters: `CLK_HZ`=20, `TICK_HZ`=2, `FAST_DIV`=5, giving `PERIOD`=10 and `FPERIOD`=2.

- **Normal run:** reset, then `en`=1 for 35 cycles → `tick` on enabled cycles 10, 20, 30 only; `blink` runs 5 high / 5 low; `phase` follows 0..9.
- **Pause:** `en`=0 for 7 cycles at `phase`=4 → `phase` holds at 4, `tick`=0; the next tick comes exactly 6 enabled cycles after resume.
- **Fast switch:** assert `fast` at `phase`=7 → wrap on the next enabled cycle with one `tick`. After that, ticks every 2 cycles with `blink` alternating 1,0.
- **Clear vs enable:** `clr`=`en`=1 at `phase`=9 → `phase`=0, `tick`=0, `blink`=1. The next tick comes 10 cycles later.
- **Reset mid-period:** `rst` at `phase`=6 → all outputs 0 next cycle; no tick until 10 enabled cycles after release.
- **Long-run check:** `PERIOD`=100_000_000 build, 3×10^8 enabled cycles → exactly 3 ticks, spaced 10^8 cycles apart.
